// File: rtl/main_memory_block_reader_if.sv
// rtl/main_memory_block_reader_if.sv - block-read handshake between cache controller and main memory
interface main_memory_block_reader_if #(
  parameter int ADDR_W      = 15,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4
);
  logic                          MMRead;
  logic [ADDR_W-1:0]             Address;
  logic                          MMDataReady;
  logic [WORD_W*BLOCK_WORDS-1:0] BlockData;
  logic                          Busy;

  modport master (
    output MMRead,
    output Address,
    input  MMDataReady,
    input  BlockData,
    input  Busy
  );

  modport slave (
    input  MMRead,
    input  Address,
    output MMDataReady,
    output BlockData,
    output Busy
  );
endinterface

// File: rtl/main_memory_block_reader.sv
// rtl/main_memory_block_reader.sv - main-memory model returning one cache block after a fixed latency
module main_memory_block_reader #(
  parameter int    ADDR_W      = 15,
  parameter int    WORD_W      = 32,
  parameter int    BLOCK_WORDS = 4,
  parameter int    LATENCY     = 8,
  parameter string INIT_FILE   = ""
) (
  input  logic                       clk,
  input  logic                       rst,
  main_memory_block_reader_if.slave  mm
);
  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FETCH,
    S_READY,
    S_RELEASE
  } state_t;

  logic [WORD_W-1:0]             r_mem [0:DEPTH-1];
  logic [WORD_W-1:0]             r_shadow [0:BLOCK_WORDS-1];
  state_t                        r_state;
  logic [CNT_W-1:0]              r_cnt;
  logic [IDX_W-1:0]              r_idx;
  logic [ADDR_W-1:0]             r_base;
  logic [WORD_W*BLOCK_WORDS-1:0] r_block_data;
  logic                          r_ready;
  logic                          r_busy;

  logic [ADDR_W-1:0]             w_rd_addr;
  logic [WORD_W-1:0]             w_rd_word;
  logic [WORD_W*BLOCK_WORDS-1:0] w_block_next;

  // Power-up image only; the array has no write port and reset leaves it alone.
  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
  end

  // base is block-aligned, so OR-ing the index can never leave the block.
  assign w_rd_addr = r_base | ADDR_W'(r_idx);
  assign w_rd_word = r_mem[w_rd_addr];

  always_comb begin
    w_block_next = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      if (IDX_W'(i) == r_idx) w_block_next[i*WORD_W +: WORD_W] = w_rd_word;
      else                    w_block_next[i*WORD_W +: WORD_W] = r_shadow[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_base       <= '0;
      r_block_data <= '0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) r_shadow[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          if (mm.MMRead) begin
            r_base  <= {mm.Address[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!mm.MMRead) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_idx   <= '0;
            r_state <= S_FETCH;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FETCH: begin
          // A dropped request wins even on the last word: nothing is published.
          if (!mm.MMRead) begin
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_shadow[r_idx] <= w_rd_word;
            if (r_idx == IDX_W'(BLOCK_WORDS - 1)) begin
              r_block_data <= w_block_next;
              r_ready      <= 1'b1;
              r_state      <= S_READY;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_READY: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          // Hold here until the controller lowers MMRead so the old request is not re-accepted.
          if (!mm.MMRead) r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mm.MMDataReady = r_ready;
  assign mm.BlockData   = r_block_data;
  assign mm.Busy        = r_busy;
endmodule

// File: tb/tb_main_memory_block_reader.sv
// tb/tb_main_memory_block_reader.sv - randomized self-checking bench with a behavioural block-read model
module tb_main_memory_block_reader;
  localparam int AW  = 15;
  localparam int WW  = 32;
  localparam int BW  = 4;
  localparam int LAT = 8;
  localparam int RL  = LAT + BW;
  localparam int BDW = WW * BW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  main_memory_block_reader_if #(.ADDR_W(AW), .WORD_W(WW), .BLOCK_WORDS(BW)) mm ();

  main_memory_block_reader #(
    .ADDR_W(AW), .WORD_W(WW), .BLOCK_WORDS(BW), .LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .mm (mm)
  );

  logic [WW-1:0]  ref_mem [0:(1<<AW)-1];
  logic [BDW-1:0] ref_block;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [BDW-1:0] got, input logic [BDW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BDW-1:0] block_of(input logic [AW-1:0] a);
    logic [BDW-1:0] r;
    int base;
    base = (int'(a) / BW) * BW;
    for (int i = 0; i < BW; i++) r[i*WW +: WW] = ref_mem[base + i];
    return r;
  endfunction

  // n counts edges after the accept edge E0; drop/rst/chg act on the edge E0+n.
  task automatic run(input logic [AW-1:0] addr, input int drop_at, input int rst_at,
                     input int chg_at, input logic [AW-1:0] chg_addr, input int hold);
    logic [BDW-1:0] exp;
    int  busy_n;
    bit  done;
    busy_n = 0;
    done   = 1'b0;
    exp    = block_of(addr);
    mm.MMRead  = 1'b1;
    mm.Address = addr;
    for (int n = 0; n <= RL && !done; n++) begin
      if (n == chg_at)  mm.Address = chg_addr;
      if (n == drop_at) mm.MMRead  = 1'b0;
      if (n == rst_at) begin
        rst       = 1'b0;
        mm.MMRead = 1'b0;
      end
      step();
      rst = 1'b1;
      if (n == drop_at || n == rst_at) begin
        if (n == rst_at) ref_block = '0;
        check("abort_rdy",  BDW'(mm.MMDataReady), '0);
        check("abort_busy", BDW'(mm.Busy), '0);
        check("abort_blk",  mm.BlockData, ref_block);
        done = 1'b1;
      end else begin
        check("rdy_timing", BDW'(mm.MMDataReady), BDW'(n == RL));
        if (mm.Busy) busy_n++;
      end
    end
    if (!done) begin
      ref_block = exp;
      check("block", mm.BlockData, ref_block);
      check("busy_cycles", BDW'(busy_n), BDW'(RL + 1));
      for (int h = 0; h < hold; h++) begin
        step();
        check("release_rdy",  BDW'(mm.MMDataReady), '0);
        check("release_busy", BDW'(mm.Busy), '0);
      end
    end
    mm.MMRead = 1'b0;
    step();
    step();
    check("idle_rdy",  BDW'(mm.MMDataReady), '0);
    check("idle_busy", BDW'(mm.Busy), '0);
    check("idle_blk",  mm.BlockData, ref_block);
  endtask

  initial begin
    logic [AW-1:0]  a;
    logic [AW-1:0]  a2;
    logic [BDW-1:0] k;
    int mode;
    int drop_at;
    int rst_at;
    int chg_at;
    mm.MMRead  = 1'b0;
    mm.Address = '0;
    #1;
    for (int i = 0; i < (1 << AW); i++) begin
      ref_mem[i]   = 32'hA000_0000 + i;
      dut.r_mem[i] = ref_mem[i];
    end
    ref_block = '0;
    rst = 1'b0;
    step();
    step();
    check("reset_rdy",  BDW'(mm.MMDataReady), '0);
    check("reset_busy", BDW'(mm.Busy), '0);
    check("reset_blk",  mm.BlockData, '0);
    rst = 1'b1;
    step();

    run(15'h0006, -1, -1, -1, '0, 0);
    k = 128'hA0000007_A0000006_A0000005_A0000004;
    check("t1_const", mm.BlockData, k);

    run(15'h7FFF, -1, -1, -1, '0, 0);
    k = 128'hA0007FFF_A0007FFE_A0007FFD_A0007FFC;
    check("t2_const", mm.BlockData, k);

    run(15'h0006, -1, -1, -1, '0, 3);
    run(15'h0020, -1, -1, -1, '0, 0);

    run(15'h0006, -1, -1, -1, '0, 0);
    run(15'h0040, 5,  -1, -1, '0, 0);
    run(15'h0040, 10, -1, -1, '0, 0);
    run(15'h0040, RL, -1, -1, '0, 0);
    k = 128'hA0000007_A0000006_A0000005_A0000004;
    check("t4_kept", mm.BlockData, k);

    run(15'h0030, -1, 10, -1, '0, 0);
    run(15'h0010, -1, -1, -1, '0, 0);
    k = 128'hA0000013_A0000012_A0000011_A0000010;
    check("t5_const", mm.BlockData, k);

    run(15'h0004, -1, -1, 1, 15'h0100, 0);
    k = 128'hA0000007_A0000006_A0000005_A0000004;
    check("t6_const", mm.BlockData, k);

    for (int i = 0; i < 64; i++) begin
      a = AW'($urandom);
      ref_mem[a]   = $urandom;
      dut.r_mem[a] = ref_mem[a];
    end
    for (int it = 0; it < 40; it++) begin
      a       = AW'($urandom);
      a2      = AW'($urandom);
      mode    = int'($urandom_range(0, 9));
      drop_at = (mode < 3)  ? int'($urandom_range(1, RL)) : -1;
      rst_at  = (mode == 3) ? int'($urandom_range(0, RL)) : -1;
      chg_at  = (mode > 6)  ? int'($urandom_range(1, RL)) : -1;
      run(a, drop_at, rst_at, chg_at, a2, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
